cpu_param: RTL and testbench
============================

# cpu_param

Parametrised accumulator CPU that generalises the team's fixed 2-bit CPU.
- Data width and program depth are configurable.
- Adds a writable program memory, a zero flag, conditional branch, explicit halt, and a qualified output strobe.
- Sits at the top of the small-computer hierarchy and is driven directly by a bench or a loader block.

## Interface
- DATA_W, 4, accumulator/immediate/output width; ≥2.
- ADDR_W, 4, program counter width; depth = 2**ADDR_W; must be ≤ DATA_W.
- INSTR_W, 3+DATA_W, derived; instruction = {op[2:0], imm[DATA_W-1:0]}.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; asserting (0) forces reset state immediately.
- prog_we  in  1  program-memory write enable.
- prog_addr  in  ADDR_W  write address.
- prog_data  in  INSTR_W  write data.
- run  in  1  start/restart pulse.
- output_data  out  DATA_W  last value emitted by OUT.
- output_valid  out  1  one-cycle strobe, high in the cycle after OUT executes.
- halted  out  1  high while in HALT.
- busy  out  1  high in FETCH or EXEC.
- pc  out  ADDR_W  current program counter (debug).

## Operation
- States: IDLE → FETCH → EXEC → FETCH …; EXEC on HLT → HALT.
- IDLE/HALT on run=1 → FETCH with pc=0 and acc=0; the zero flag z is recomputed from acc.
- prog_we is honoured only in IDLE/HALT; writes during FETCH/EXEC are dropped.
- If run and prog_we arrive in the same cycle in IDLE/HALT, both take effect; the write lands before the first fetch.
- FETCH: ir ← mem[pc].
- EXEC decodes ir.op:
  - 0 NOP.
  - 1 LDI: acc ← imm.
  - 2 ADD: acc ← acc+imm mod 2**DATA_W.
  - 3 SUB: acc ← acc−imm mod 2**DATA_W.
  - 4 JMP: pc ← imm[ADDR_W-1:0].
  - 5 JZ: if z then pc ← imm[ADDR_W-1:0].
  - 6 OUT: output_data ← acc, output_valid ← 1.
  - 7 HLT: → HALT, pc holds.
- Non-jump (and untaken JZ) instructions: pc ← pc+1, wrapping from 2**ADDR_W−1 to 0.
- z = (acc==0), updated after LDI/ADD/SUB only.
- run while busy is ignored.
- Memory contents are not cleared by reset; a write followed by reset retains the written value.

## Timing
- Reset values:
  - state=IDLE, pc=0, acc=0, z=1, ir=0.
  - output_data=0, output_valid=0, halted=0, busy=0.
- Every instruction takes exactly 2 cycles (FETCH, EXEC). No stalls.
- run sampled high at edge t → FETCH during cycle t+1, first EXEC in cycle t+2.
- OUT executed in EXEC cycle k → output_data and output_valid=1 registered at the edge ending k. The strobe is high for exactly one cycle, then drops; output_data holds.
- halted rises at the edge ending the HLT EXEC cycle.
- Memory write: synchronous, lands at the edge where prog_we=1. Read is combinational from the array into ir.
- Reset mid-operation aborts immediately to IDLE. output_valid drops without waiting for the clock.

## Structure
- Package cpu_param_pkg holds:
  - opcode localparams OP_NOP..OP_HLT (3 bits);
  - state encoding ST_IDLE, ST_FETCH, ST_EXEC, ST_HALT (2 bits).
- Sub-module cpu_prog_mem (ADDR_W, INSTR_W):
  - register array;
  - synchronous write, asynchronous read;
  - no reset.
- Top holds the FSM, datapath, and output registers.

## Test plan
- Reset check (DATA_W=4, ADDR_W=4): hold reset=0 for 2 cycles → all outputs at reset values; release, no run → stays IDLE, busy=0.
- Load LDI 3, ADD 2, OUT, HLT, then run pulse → output_data=5 with a single-cycle output_valid 6 cycles after run. halted=1 at cycle 8; pc=3 holds.
- Wrap and branch: LDI 15, ADD 1, JZ 5, OUT, HLT, OUT(at 5), HLT → acc=0, z=1, branch taken. Exactly one strobe with output_data=0, pc=6 at halt.
- SUB underflow: LDI 0, SUB 1, OUT, HLT → output_data=15, z=0.
- prog_we asserted during busy to address 2 → mem[2] unchanged; verify by rerunning and comparing output.
- Reset asserted mid-EXEC of an OUT → output_valid never strobes, state IDLE. Subsequent run restarts from pc=0 with the program intact.

Source files
------------

// File: rtl/cpu_param_pkg.sv
// Shared opcode and state definitions for the parametrised accumulator CPU.
package cpu_param_pkg;

  // Instruction opcodes, carried in the top three bits of every instruction word
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDI = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_JMP = 3'd4;
  localparam logic [2:0] OP_JZ  = 3'd5;
  localparam logic [2:0] OP_OUT = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  // Control FSM states; every instruction visits FETCH then EXEC
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_prog_mem.sv
// Program memory: register array with a synchronous write port and a
// combinational read port. Contents survive reset on purpose, so a program
// loaded once can be rerun after any reset.
module cpu_prog_mem #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 7
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_q [2**ADDR_W];

  // Write lands at the clock edge where we is high; there is no reset on the array
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cpu_param.sv
// Parametrised accumulator CPU: IDLE/HALT wait for run, then each instruction
// takes one FETCH cycle (ir <- mem[pc]) and one EXEC cycle. ADDR_W is expected
// to be no wider than DATA_W so jump targets fit in the immediate field.
module cpu_param
  import cpu_param_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 3 + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               run,
  output logic [DATA_W-1:0]  output_data,
  output logic               output_valid,
  output logic               halted,
  output logic               busy,
  output logic [ADDR_W-1:0]  pc
);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic                 z_q, z_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]    output_data_q, output_data_d;
  logic                 output_valid_q, output_valid_d;

  logic                 mem_we;
  logic [INSTR_W-1:0]   mem_rdata;
  logic [2:0]           op;
  logic [DATA_W-1:0]    imm;
  logic                 idle_like;

  assign op        = ir_q[INSTR_W-1 -: 3];
  assign imm       = ir_q[DATA_W-1:0];
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_HALT);

  // Loader writes are only accepted while the core is not executing
  assign mem_we = prog_we && idle_like;

  cpu_prog_mem #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (mem_rdata)
  );

  // FSM state register; reset aborts straight to IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: run starts from IDLE/HALT, HLT parks in HALT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HALT: if (run) state_d = ST_FETCH;
      ST_FETCH:         state_d = ST_EXEC;
      ST_EXEC:          state_d = (op == OP_HLT) ? ST_HALT : ST_FETCH;
      default:          state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    busy   = 1'b0;
    halted = 1'b0;
    case (state_q)
      ST_FETCH, ST_EXEC: busy   = 1'b1;
      ST_HALT:           halted = 1'b1;
      default: begin
        busy   = 1'b0;
        halted = 1'b0;
      end
    endcase
  end

  // Datapath next values: run clears pc/acc, FETCH loads ir, EXEC decodes ir
  always_comb begin
    pc_d           = pc_q;
    acc_d          = acc_q;
    z_d            = z_q;
    ir_d           = ir_q;
    output_data_d  = output_data_q;
    output_valid_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (run) begin
          pc_d  = '0;
          acc_d = '0;
          z_d   = 1'b1;
        end
      end
      ST_FETCH: begin
        ir_d = mem_rdata;
      end
      ST_EXEC: begin
        pc_d = pc_q + ADDR_W'(1);
        case (op)
          OP_LDI: begin
            acc_d = imm;
            z_d   = (imm == '0);
          end
          OP_ADD: begin
            acc_d = acc_q + imm;
            z_d   = ((acc_q + imm) == '0);
          end
          OP_SUB: begin
            acc_d = acc_q - imm;
            z_d   = ((acc_q - imm) == '0);
          end
          OP_JMP: begin
            pc_d = imm[ADDR_W-1:0];
          end
          OP_JZ: begin
            if (z_q) pc_d = imm[ADDR_W-1:0];
          end
          OP_OUT: begin
            output_data_d  = acc_q;
            output_valid_d = 1'b1;
          end
          OP_HLT: begin
            pc_d = pc_q;
          end
          default: begin
            pc_d = pc_q + ADDR_W'(1);
          end
        endcase
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // Datapath and output registers; reset clears everything except memory
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q           <= '0;
      acc_q          <= '0;
      z_q            <= 1'b1;
      ir_q           <= '0;
      output_data_q  <= '0;
      output_valid_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      acc_q          <= acc_d;
      z_q            <= z_d;
      ir_q           <= ir_d;
      output_data_q  <= output_data_d;
      output_valid_q <= output_valid_d;
    end
  end

  assign output_data  = output_data_q;
  assign output_valid = output_valid_q;
  assign pc           = pc_q;

endmodule

// File: tb/tb_cpu_param.sv
// Self-checking bench for cpu_param: expected OUT values are queued before each
// run and popped whenever the core strobes output_valid.
module tb_cpu_param;
  import cpu_param_pkg::*;

  localparam int DATA_W  = 4;
  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 3 + DATA_W;

  logic               clk;
  logic               reset;
  logic               prog_we;
  logic [ADDR_W-1:0]  prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic               run;
  logic [DATA_W-1:0]  output_data;
  logic               output_valid;
  logic               halted;
  logic               busy;
  logic [ADDR_W-1:0]  pc;

  int testsRun    = 0;
  int testsFailed = 0;
  int strobeCount = 0;
  int strobeEdge;
  int haltEdge;
  logic [DATA_W-1:0] expQ[$];

  cpu_param #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .run          (run),
    .output_data  (output_data),
    .output_valid (output_valid),
    .halted       (halted),
    .busy         (busy),
    .pc           (pc)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Writes one instruction word into program memory
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [2:0] op, input logic [DATA_W-1:0] imm);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = {op, imm};
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  // Pulses run and counts edges (after the run edge) until first strobe and halt
  task automatic runProgram(output int firstStrobe, output int haltAt);
    firstStrobe = -1;
    haltAt      = -1;
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #1;
      if (output_valid && firstStrobe < 0) firstStrobe = n;
      if (halted) begin
        haltAt = n;
        break;
      end
    end
    checkOutput("haltReached", (haltAt > 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (output_valid === 1'b1) begin
      strobeCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedStrobe", 32'd1, 32'd0);
      end else begin
        checkOutput("outData", output_data, expQ.pop_front());
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    run       = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstOutData", output_data, 0);
    checkOutput("rstOutValid", output_valid, 0);
    checkOutput("rstHalted", halted, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstPc", pc, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idleBusy", busy, 0);
    checkOutput("idleHalted", halted, 0);
    checkOutput("idlePc", pc, 0);

    // LDI 3, ADD 2, OUT, HLT
    applyStimulus(0, OP_LDI, 3);
    applyStimulus(1, OP_ADD, 2);
    applyStimulus(2, OP_OUT, 0);
    applyStimulus(3, OP_HLT, 0);
    expQ.push_back(5);
    strobeCount = 0;
    runProgram(strobeEdge, haltEdge);
    checkOutput("basicStrobeEdge", strobeEdge, 6);
    checkOutput("basicHaltEdge", haltEdge, 8);
    checkOutput("basicStrobes", strobeCount, 1);
    checkOutput("basicPc", pc, 3);
    checkOutput("basicHold", output_data, 5);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("basicPcHolds", pc, 3);
    checkOutput("basicStillHalted", halted, 1);
    checkOutput("basicQueueEmpty", expQ.size(), 0);

    // Accumulator wrap to zero, JZ taken
    applyStimulus(0, OP_LDI, 15);
    applyStimulus(1, OP_ADD, 1);
    applyStimulus(2, OP_JZ, 5);
    applyStimulus(3, OP_OUT, 0);
    applyStimulus(4, OP_HLT, 0);
    applyStimulus(5, OP_OUT, 0);
    applyStimulus(6, OP_HLT, 0);
    expQ.push_back(0);
    strobeCount = 0;
    runProgram(strobeEdge, haltEdge);
    checkOutput("wrapStrobes", strobeCount, 1);
    checkOutput("wrapPc", pc, 6);
    checkOutput("wrapOutData", output_data, 0);
    checkOutput("wrapQueueEmpty", expQ.size(), 0);

    // SUB underflow, z must be clear so JZ falls through
    applyStimulus(0, OP_LDI, 0);
    applyStimulus(1, OP_SUB, 1);
    applyStimulus(2, OP_OUT, 0);
    applyStimulus(3, OP_JZ, 6);
    applyStimulus(4, OP_HLT, 0);
    applyStimulus(6, OP_OUT, 0);
    applyStimulus(7, OP_HLT, 0);
    expQ.push_back(15);
    strobeCount = 0;
    runProgram(strobeEdge, haltEdge);
    checkOutput("subStrobes", strobeCount, 1);
    checkOutput("subPc", pc, 4);
    checkOutput("subOutData", output_data, 15);
    checkOutput("subQueueEmpty", expQ.size(), 0);

    // z=1 after run so JZ 14 is taken; pc wraps 15 -> 0, second JZ not taken
    applyStimulus(0, OP_JZ, 14);
    applyStimulus(14, OP_LDI, 2);
    applyStimulus(15, OP_OUT, 0);
    applyStimulus(1, OP_HLT, 0);
    expQ.push_back(2);
    strobeCount = 0;
    runProgram(strobeEdge, haltEdge);
    checkOutput("pcWrapStrobes", strobeCount, 1);
    checkOutput("pcWrapPc", pc, 1);
    checkOutput("pcWrapQueueEmpty", expQ.size(), 0);

    // Write while busy must be dropped
    applyStimulus(0, OP_LDI, 7);
    applyStimulus(1, OP_NOP, 0);
    applyStimulus(2, OP_OUT, 0);
    applyStimulus(3, OP_HLT, 0);
    expQ.push_back(7);
    strobeCount = 0;
    fork
      runProgram(strobeEdge, haltEdge);
      begin
        repeat (3) @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = 2;
        prog_data = {OP_LDI, 4'd9};
        repeat (2) @(negedge clk);
        prog_we   = 1'b0;
      end
    join
    checkOutput("busyWrStrobes", strobeCount, 1);
    checkOutput("busyWrPc", pc, 3);
    expQ.push_back(7);
    strobeCount = 0;
    runProgram(strobeEdge, haltEdge);
    checkOutput("busyWrRerunStrobes", strobeCount, 1);
    checkOutput("busyWrRerunData", output_data, 7);
    checkOutput("busyWrQueueEmpty", expQ.size(), 0);

    // Reset during the EXEC cycle of an OUT
    applyStimulus(0, OP_LDI, 5);
    applyStimulus(1, OP_OUT, 0);
    applyStimulus(2, OP_HLT, 0);
    strobeCount = 0;
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midOutBusy", busy, 1);
    checkOutput("midOutPc", pc, 1);
    #1 reset = 1'b0;
    #1;
    checkOutput("abortValid", output_valid, 0);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortHalted", halted, 0);
    checkOutput("abortPc", pc, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abortIdleBusy", busy, 0);
    checkOutput("abortStrobes", strobeCount, 0);
    expQ.push_back(5);
    runProgram(strobeEdge, haltEdge);
    checkOutput("restartStrobeEdge", strobeEdge, 4);
    checkOutput("restartHaltEdge", haltEdge, 6);
    checkOutput("restartStrobes", strobeCount, 1);
    checkOutput("restartPc", pc, 2);
    checkOutput("restartData", output_data, 5);
    checkOutput("restartQueueEmpty", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
